ram_arbiter: RTL and testbench

- Shares the single block-wide RAM port between the instruction cache (read-only) and the data cache (read/write) in the multicycle OTTER variable-latency memory system.
- Sits between both cache miss/writeback ports and the RAM controller.
- Serialises block transfers with round-robin arbitration, registers the request at grant, waits for the RAM's variable-latency completion, and routes the response back to the owner.
- Runs a watchdog on every RAM transaction.

---
 rtl/ram_arbiter_pkg.sv | 8 +
 rtl/ram_arbiter_rr.sv | 15 +
 rtl/ram_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared sizes and enums for the OTTER cache-to-RAM bus.
package memory_bus_sizes;
    localparam int ADDR_W  = 32;
    localparam int BLOCK_W = 128;

    typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} owner_t;
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} arb_state_t;
endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-requester round-robin grant: on a tie the side that did not win last time goes.
import memory_bus_sizes::*;

module rr_arbiter2 (
    input  logic   i_req_i,
    input  logic   i_req_d,
    input  owner_t i_last,
    output logic   o_gnt_i,
    output logic   o_gnt_d
);
    always_comb begin
        o_gnt_d = i_req_d && (!i_req_i || (i_last == ICACHE));
        o_gnt_i = i_req_i && (!i_req_d || (i_last == DCACHE));
    end
endmodule

// File: rtl/ram_arbiter.sv
// Serialises icache/dcache block transfers onto one RAM port, with a watchdog per transaction.
import memory_bus_sizes::*;

module ram_arbiter #(
    parameter int ADDR_W  = memory_bus_sizes::ADDR_W,
    parameter int BLOCK_W = memory_bus_sizes::BLOCK_W,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_req_valid,
    input  logic [ADDR_W-1:0]  i_req_addr,
    output logic               i_req_ready,
    output logic               i_resp_valid,
    output logic [BLOCK_W-1:0] i_resp_rdata,
    input  logic               d_req_valid,
    input  logic               d_req_we,
    input  logic [ADDR_W-1:0]  d_req_addr,
    input  logic [BLOCK_W-1:0] d_req_wdata,
    output logic               d_req_ready,
    output logic               d_resp_valid,
    output logic [BLOCK_W-1:0] d_resp_rdata,
    output logic               ram_req,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [BLOCK_W-1:0] ram_wdata,
    input  logic               ram_done,
    input  logic [BLOCK_W-1:0] ram_rdata,
    output logic               busy,
    output logic               timeout_err
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_t         r_state, w_next;
    owner_t             r_owner, r_last;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic [BLOCK_W-1:0] r_wdata, r_rdata;
    logic [WD_W-1:0]    r_wdog;
    logic               r_terr;
    logic               w_idle, w_gnt_i, w_gnt_d, w_timeout;

    assign w_idle = (r_state == IDLE);

    rr_arbiter2 u_rr (
        .i_req_i (i_req_valid && w_idle),
        .i_req_d (d_req_valid && w_idle),
        .i_last  (r_last),
        .o_gnt_i (w_gnt_i),
        .o_gnt_d (w_gnt_d)
    );

    // ram_done wins over an expiring watchdog in the same cycle
    assign w_timeout = (r_state == BUS) && !ram_done && (r_wdog == WD_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt_i || w_gnt_d) w_next = BUS;
            BUS:     if (ram_done || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= ICACHE;
            r_last  <= ICACHE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wdog  <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    r_wdog <= '0;
                    if (w_gnt_d) begin
                        r_addr  <= d_req_addr;
                        r_we    <= d_req_we;
                        r_wdata <= d_req_wdata;
                        r_owner <= DCACHE;
                        r_last  <= DCACHE;
                    end else if (w_gnt_i) begin
                        r_addr  <= i_req_addr;
                        r_we    <= 1'b0;
                        r_wdata <= '0;
                        r_owner <= ICACHE;
                        r_last  <= ICACHE;
                    end
                end
                BUS: begin
                    r_wdog <= r_wdog + WD_W'(1);
                    if (ram_done) begin
                        r_rdata <= ram_rdata;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_terr  <= 1'b1;
                    end
                end
                RESP:    r_wdog <= '0;
                default: r_wdog <= '0;
            endcase
        end
    end

    assign i_req_ready  = w_gnt_i;
    assign d_req_ready  = w_gnt_d;
    assign i_resp_valid = (r_state == RESP) && (r_owner == ICACHE);
    assign d_resp_valid = (r_state == RESP) && (r_owner == DCACHE);
    assign i_resp_rdata = r_rdata;
    assign d_resp_rdata = r_rdata;
    assign ram_req      = (r_state == BUS);
    assign ram_we       = r_we;
    assign ram_addr     = r_addr;
    assign ram_wdata    = r_wdata;
    assign busy         = !w_idle;
    assign timeout_err  = r_terr;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: cache request drivers, a variable-latency RAM model and a monitor.
module tb_ram_arbiter;
    localparam int TO = 16;

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [127:0] wdata;
    } cmd_t;

    typedef struct {
        logic         own;
        logic [31:0]  addr;
        logic         we;
        logic [127:0] wdata;
        logic [127:0] exp;
        int           lat;
        int           acc;
    } sb_t;

    typedef struct {
        logic own;
        int   cyc;
    } gnt_t;

    logic         clk, rst_n;
    logic         i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0]  i_req_addr;
    logic [127:0] i_resp_rdata;
    logic         d_req_valid, d_req_we, d_req_ready, d_resp_valid;
    logic [31:0]  d_req_addr;
    logic [127:0] d_req_wdata, d_resp_rdata;
    logic         ram_req, ram_we, ram_done;
    logic [31:0]  ram_addr;
    logic [127:0] ram_wdata, ram_rdata;
    logic         busy, timeout_err;

    ram_arbiter #(.ADDR_W(32), .BLOCK_W(128), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_done(ram_done), .ram_rdata(ram_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    int   ram_lat = 5;
    logic ram_hang = 1'b0;
    logic spur_done = 1'b0;
    int   bus_cnt = 0;
    int   d_resp_cyc = 0;
    cmd_t iq[$], dq[$];
    sb_t  sb[$];
    gnt_t glog[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [127:0] ram_data(input logic [31:0] a);
        return {32'hDEADBEEF, 32'h0, a, 32'h0000_0001};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM model: completes ram_lat cycles after ram_req rises, unless hung
    initial begin
        int cnt;
        cnt = 0;
        ram_done = 1'b0;
        ram_rdata = '0;
        forever begin
            @(posedge clk); #1;
            ram_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (spur_done) begin
                ram_done = 1'b1;
                ram_rdata = '1;
            end else if (ram_req && !ram_hang) begin
                cnt++;
                if (cnt == ram_lat) begin
                    ram_done = 1'b1;
                    ram_rdata = ram_data(ram_addr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // icache driver: holds valid until ready, then scrambles its fields
    initial begin
        logic seen;
        cmd_t c;
        i_req_valid = 1'b0;
        i_req_addr = '0;
        forever begin
            @(negedge clk);
            seen = i_req_ready;
            @(posedge clk); #2;
            if (!rst_n) begin
                i_req_valid = 1'b0;
            end else begin
                if (seen) begin
                    i_req_valid = 1'b0;
                    i_req_addr = 32'hFFFF0000;
                end
                if (!i_req_valid && iq.size() > 0) begin
                    c = iq.pop_front();
                    i_req_valid = 1'b1;
                    i_req_addr = c.addr;
                end
            end
        end
    end

    initial begin
        logic seen;
        cmd_t c;
        d_req_valid = 1'b0;
        d_req_we = 1'b0;
        d_req_addr = '0;
        d_req_wdata = '0;
        forever begin
            @(negedge clk);
            seen = d_req_ready;
            @(posedge clk); #2;
            if (!rst_n) begin
                d_req_valid = 1'b0;
            end else begin
                if (seen) begin
                    d_req_valid = 1'b0;
                    d_req_addr = 32'hFFFF0000;
                    d_req_wdata = {$urandom, $urandom, $urandom, $urandom};
                end
                if (!d_req_valid && dq.size() > 0) begin
                    c = dq.pop_front();
                    d_req_valid = 1'b1;
                    d_req_we = c.we;
                    d_req_addr = c.addr;
                    d_req_wdata = c.wdata;
                end
            end
        end
    end

    // Monitor: push expectations at accept, check the bus phase, pop at response
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                bus_cnt = 0;
            end else begin
                if (i_req_ready || d_req_ready)
                    chk("dual_ready", i_req_ready & d_req_ready, 0);
                if (i_req_ready) begin
                    e = '{1'b0, i_req_addr, 1'b0, 128'h0,
                          ram_hang ? 128'h0 : ram_data(i_req_addr), ram_hang ? TO : ram_lat, cyc};
                    sb.push_back(e);
                    glog.push_back('{1'b0, cyc});
                end
                if (d_req_ready) begin
                    e = '{1'b1, d_req_addr, d_req_we, d_req_wdata,
                          ram_hang ? 128'h0 : ram_data(d_req_addr), ram_hang ? TO : ram_lat, cyc};
                    sb.push_back(e);
                    glog.push_back('{1'b1, cyc});
                end
                if (ram_req) begin
                    bus_cnt++;
                    if (sb.size() == 0) begin
                        chk("ram_req_no_txn", ram_req, 0);
                    end else begin
                        chk("ram_addr", ram_addr, sb[0].addr);
                        chk("ram_we", ram_we, sb[0].we);
                        if (sb[0].we) chk("ram_wdata", ram_wdata, sb[0].wdata);
                    end
                end
                if (i_resp_valid || d_resp_valid) begin
                    chk("dual_resp", i_resp_valid & d_resp_valid, 0);
                    if (sb.size() == 0) begin
                        chk("resp_no_txn", {i_resp_valid, d_resp_valid}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_owner", d_resp_valid, e.own);
                        if (!e.we) chk("resp_data", e.own ? d_resp_rdata : i_resp_rdata, e.exp);
                        chk("resp_latency", cyc - e.acc, e.lat + 1);
                        chk("bus_cycles", bus_cnt, e.lat);
                        if (e.own) d_resp_cyc = cyc;
                    end
                    bus_cnt = 0;
                end
            end
        end
    end

    task automatic drain(input int lim);
        int k;
        k = 0;
        while (k < lim && !(iq.size() == 0 && dq.size() == 0 && !i_req_valid &&
                            !d_req_valid && sb.size() == 0 && !busy)) begin
            @(negedge clk);
            k++;
        end
        chk("drain_in_time", k < lim, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ram_req", ram_req, 0);
        chk("rst_ready", {i_req_ready, d_req_ready}, 0);
        chk("rst_resp", {i_resp_valid, d_resp_valid}, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_ram_fields", {ram_we, ram_addr, ram_wdata}, 0);
        chk("rst_rdata", i_resp_rdata | d_resp_rdata, 0);
        @(posedge clk); #3 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int base, gap;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Single icache read, latency 5
        ram_lat = 5;
        @(negedge clk); #1;
        iq.push_back('{32'h40, 1'b0, 128'h0});
        drain(100);
        chk("terr_clean", timeout_err, 0);

        // Simultaneous requests after reset: dcache write wins first
        do_reset();
        ram_lat = 3;
        base = glog.size();
        @(negedge clk); #1;
        dq.push_back('{32'h80, 1'b1, {4{32'hA5A5A5A5}}});
        iq.push_back('{32'h200, 1'b0, 128'h0});
        drain(100);
        chk("tie_first_d", glog[base].own, 1);
        chk("tie_then_i", glog[base+1].own, 0);
        chk("i_after_dresp", glog[base+1].cyc, d_resp_cyc + 1);

        // Both held continuously: strict alternation
        ram_lat = 1;
        base = glog.size();
        @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            dq.push_back('{32'h1000 + 32'(k * 16), k[0], {4{$urandom}}});
            iq.push_back('{32'h2000 + 32'(k * 16), 1'b0, 128'h0});
        end
        drain(200);
        for (int k = 0; k < 6; k++) begin
            chk("rr_order", glog[base+k].own, (k % 2 == 0) ? 1 : 0);
            if (k > 0) begin
                gap = glog[base+k].cyc - glog[base+k-1].cyc;
                chk("rr_gap_ge3", gap >= 3, 1);
            end
        end

        // RAM never completes: watchdog releases the owner
        ram_hang = 1'b1;
        @(negedge clk); #1;
        dq.push_back('{32'h100, 1'b0, 128'h0});
        drain(100);
        chk("terr_set", timeout_err, 1);
        ram_hang = 1'b0;
        ram_lat = 2;
        @(negedge clk); #1;
        iq.push_back('{32'h140, 1'b0, 128'h0});
        drain(100);
        chk("terr_sticky", timeout_err, 1);

        // Reset in the third BUS cycle, then a stray ram_done
        ram_lat = 8;
        @(negedge clk); #1;
        dq.push_back('{32'h300, 1'b0, 128'h0});
        begin
            int k;
            k = 0;
            while (k < 50 && !d_req_ready) begin
                @(negedge clk);
                k++;
            end
            chk("mid_accept_seen", d_req_ready, 1);
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        spur_done = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ram_req", ram_req, 0);
        chk("mid_rst_resp", {i_resp_valid, d_resp_valid}, 0);
        @(posedge clk); #3 spur_done = 1'b0;
        @(negedge clk);
        chk("spur_busy", busy, 0);
        @(negedge clk);
        chk("spur_busy_after", busy, 0);
        chk("spur_ram_req", ram_req, 0);
        chk("mid_rst_terr", timeout_err, 0);

        ram_lat = 2;
        @(negedge clk); #1;
        iq.push_back('{32'h500, 1'b0, 128'h0});
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
